// File: rtl/nmi_arb_pkg.sv
// Shared types and constants for the NMI fabric arbiters.
package nmi_arb_pkg;

  typedef enum logic {
    IDLE,
    BUSY
  } arb_state_e;

  localparam int NMI_AW = 32;
  localparam int NMI_DW = 32;
  localparam int NMI_SW = 4;

  localparam logic [NMI_DW-1:0] NMI_ERR_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request after 'last', wrapping.
module rr_pick #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] pos;

  // Scan from farthest to nearest so the closest requester after 'last' wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    pos = '0;
    for (int i = N; i >= 1; i--) begin
      pos = IW'((int'(last) + i) % N);
      if (req[pos]) begin
        gnt      = '0;
        gnt[pos] = 1'b1;
        idx      = pos;
      end
    end
  end

endmodule

// File: rtl/nmi_rr_arbiter.sv
// Round-robin arbiter sharing one NMI slave port among NUM_MST masters,
// with a per-transaction watchdog and sticky timeout status.
module nmi_rr_arbiter
  import nmi_arb_pkg::*;
#(
  parameter int                NUM_MST   = 2,
  parameter int                TIMEOUT   = 1024,
  parameter logic [NMI_DW-1:0] ERR_RDATA = NMI_ERR_RDATA
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_MST-1:0]         m_valid_i,
  input  logic [NUM_MST*NMI_AW-1:0]  m_addr_i,
  input  logic [NUM_MST*NMI_DW-1:0]  m_wdata_i,
  input  logic [NUM_MST*NMI_SW-1:0]  m_wstrb_i,
  output logic [NMI_DW-1:0]          m_rdata_o,
  output logic [NUM_MST-1:0]         m_ready_o,
  output logic                       s_valid_o,
  output logic [NMI_AW-1:0]          s_addr_o,
  output logic [NMI_DW-1:0]          s_wdata_o,
  output logic [NMI_SW-1:0]          s_wstrb_o,
  input  logic [NMI_DW-1:0]          s_rdata_i,
  input  logic                       s_ready_i,
  output logic [NUM_MST-1:0]         gnt_o,
  input  logic                       err_clr_i,
  output logic                       err_o,
  output logic [NMI_AW-1:0]          err_addr_o,
  output logic [$clog2(NUM_MST)-1:0] err_mst_o
);

  localparam int IW = $clog2(NUM_MST);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam logic [CW-1:0] CNT_MAX  = '1;

  arb_state_e        state, state_next;
  logic [NUM_MST-1:0] gnt, pick_gnt;
  logic [IW-1:0]     gnt_idx, last, pick_idx;
  logic [CW-1:0]     cnt;
  logic              active, done, timeout_hit;
  logic              err;
  logic [NMI_AW-1:0] err_addr;
  logic [IW-1:0]     err_mst;

  logic [NMI_AW-1:0] addr_arr  [NUM_MST];
  logic [NMI_DW-1:0] wdata_arr [NUM_MST];
  logic [NMI_SW-1:0] wstrb_arr [NUM_MST];

  for (genvar k = 0; k < NUM_MST; k++) begin : g_split
    assign addr_arr[k]  = m_addr_i[NMI_AW*k +: NMI_AW];
    assign wdata_arr[k] = m_wdata_i[NMI_DW*k +: NMI_DW];
    assign wstrb_arr[k] = m_wstrb_i[NMI_SW*k +: NMI_SW];
  end

  rr_pick #(.N(NUM_MST)) u_pick (
    .req  (m_valid_i),
    .last (last),
    .gnt  (pick_gnt),
    .idx  (pick_idx)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  // A dropped valid or a reset in progress silences the slave request and any completion.
  always_comb begin
    state_next  = state;
    active      = 1'b0;
    done        = 1'b0;
    timeout_hit = 1'b0;
    s_valid_o   = 1'b0;
    s_addr_o    = '0;
    s_wdata_o   = '0;
    s_wstrb_o   = '0;
    m_ready_o   = '0;
    m_rdata_o   = '0;
    case (state)
      IDLE: if (|m_valid_i) state_next = BUSY;
      BUSY: begin
        active      = m_valid_i[gnt_idx] && !rst_i;
        done        = active && s_ready_i;
        timeout_hit = (TIMEOUT != 0) && active && !s_ready_i && (cnt == CNT_LAST);
        s_valid_o   = active && !timeout_hit;
        s_addr_o    = addr_arr[gnt_idx];
        s_wdata_o   = wdata_arr[gnt_idx];
        s_wstrb_o   = wstrb_arr[gnt_idx];
        if (done) begin
          m_ready_o = gnt;
          m_rdata_o = s_rdata_i;
        end else if (timeout_hit) begin
          m_ready_o = gnt;
          m_rdata_o = ERR_RDATA;
        end
        if (!active || done || timeout_hit) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Grant, watchdog and sticky error bookkeeping; a new timeout beats a clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gnt      <= '0;
      gnt_idx  <= '0;
      last     <= IW'(NUM_MST - 1);
      cnt      <= '0;
      err      <= 1'b0;
      err_addr <= '0;
      err_mst  <= '0;
    end else begin
      if (state == IDLE && state_next == BUSY) begin
        gnt     <= pick_gnt;
        gnt_idx <= pick_idx;
        last    <= pick_idx;
        cnt     <= '0;
      end else if (state_next == IDLE) begin
        gnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
      if (timeout_hit && (!err || err_clr_i)) begin
        err      <= 1'b1;
        err_addr <= addr_arr[gnt_idx];
        err_mst  <= gnt_idx;
      end else if (err_clr_i) begin
        err <= 1'b0;
      end
    end
  end

  assign gnt_o      = gnt;
  assign err_o      = err;
  assign err_addr_o = err_addr;
  assign err_mst_o  = err_mst;

endmodule

// File: tb/tb_nmi_rr_arbiter.sv
// Self-checking bench for nmi_rr_arbiter: directed scenarios then randomized
// traffic, every cycle compared against a transaction-level reference model.
module tb_nmi_rr_arbiter;
  import nmi_arb_pkg::*;

  localparam int N  = 2;
  localparam int TO = 16;
  localparam int IW = $clog2(N);

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [N-1:0]      m_valid_i;
  logic [N*32-1:0]   m_addr_i, m_wdata_i;
  logic [N*4-1:0]    m_wstrb_i;
  logic [31:0]       m_rdata_o;
  logic [N-1:0]      m_ready_o;
  logic              s_valid_o;
  logic [31:0]       s_addr_o, s_wdata_o;
  logic [3:0]        s_wstrb_o;
  logic [31:0]       s_rdata_i;
  logic              s_ready_i;
  logic [N-1:0]      gnt_o;
  logic              err_clr_i;
  logic              err_o;
  logic [31:0]       err_addr_o;
  logic [IW-1:0]     err_mst_o;

  nmi_rr_arbiter #(.NUM_MST(N), .TIMEOUT(TO), .ERR_RDATA(32'hDEAD_BEEF)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m_valid_i(m_valid_i), .m_addr_i(m_addr_i), .m_wdata_i(m_wdata_i), .m_wstrb_i(m_wstrb_i),
    .m_rdata_o(m_rdata_o), .m_ready_o(m_ready_o),
    .s_valid_o(s_valid_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o), .s_wstrb_o(s_wstrb_o),
    .s_rdata_i(s_rdata_i), .s_ready_i(s_ready_i),
    .gnt_o(gnt_o), .err_clr_i(err_clr_i),
    .err_o(err_o), .err_addr_o(err_addr_o), .err_mst_o(err_mst_o)
  );

  always #5 clk_i = ~clk_i;

  logic [31:0] addr  [N];
  logic [31:0] wdata [N];
  logic [3:0]  strb  [N];

  always_comb begin
    for (int k = 0; k < N; k++) begin
      m_addr_i[32*k +: 32]  = addr[k];
      m_wdata_i[32*k +: 32] = wdata[k];
      m_wstrb_i[4*k +: 4]   = strb[k];
    end
  end

  int checkCount = 0;
  int errorCount = 0;

  // Reference model: who owns the slave, how many BUSY cycles it has used, and the sticky error.
  bit          mBusy, nBusy;
  int          mOwner, nOwner, mAge, nAge, mLast, nLast;
  logic        mErr, nErr;
  logic [31:0] mErrAddr, nErrAddr;
  int          mErrMst, nErrMst;
  logic [N-1:0] eGnt, eReady;
  logic        eSValid;
  logic [31:0] eRdata;

  task automatic checkValue(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    assert (act === exp) else begin
      errorCount++;
      $error("[TB] FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] v, input logic rdy, input logic [31:0] rd,
                               input logic clr, input logic rs);
    m_valid_i = v;
    s_ready_i = rdy;
    s_rdata_i = rd;
    err_clr_i = clr;
    rst_i     = rs;
    #1;
  endtask

  task automatic modelStep();
    bit found;
    eGnt = '0;
    if (mBusy) eGnt[mOwner] = 1'b1;
    eSValid = 1'b0; eReady = '0; eRdata = '0;
    nBusy = mBusy; nOwner = mOwner; nAge = mAge; nLast = mLast;
    nErr = mErr; nErrAddr = mErrAddr; nErrMst = mErrMst;
    if (rst_i) begin
      nBusy = 0; nAge = 0; nLast = N - 1;
      nErr = 1'b0; nErrAddr = '0; nErrMst = 0;
    end else begin
      if (err_clr_i) nErr = 1'b0;
      if (!mBusy) begin
        found = 0;
        for (int i = 1; i <= N; i++) begin
          int k = (mLast + i) % N;
          if (!found && m_valid_i[k]) begin
            found = 1; nBusy = 1; nOwner = k; nAge = 0; nLast = k;
          end
        end
      end else if (!m_valid_i[mOwner]) begin
        nBusy = 0;
      end else if (s_ready_i) begin
        eSValid = 1'b1; eReady[mOwner] = 1'b1; eRdata = s_rdata_i; nBusy = 0;
      end else if (mAge == TO - 1) begin
        eReady[mOwner] = 1'b1; eRdata = 32'hDEAD_BEEF; nBusy = 0;
        if (!mErr || err_clr_i) begin
          nErr = 1'b1; nErrAddr = addr[mOwner]; nErrMst = mOwner;
        end
      end else begin
        eSValid = 1'b1; nAge = mAge + 1;
      end
    end
  endtask

  task automatic checkOutput();
    modelStep();
    checkValue("gnt", 32'(gnt_o), 32'(eGnt));
    checkValue("s_valid", 32'(s_valid_o), 32'(eSValid));
    checkValue("m_ready", 32'(m_ready_o), 32'(eReady));
    checkValue("m_rdata", m_rdata_o, eRdata);
    checkValue("err", 32'(err_o), 32'(mErr));
    checkValue("err_addr", err_addr_o, mErrAddr);
    checkValue("err_mst", 32'(err_mst_o), 32'(mErrMst));
    if (eSValid) begin
      checkValue("s_addr", s_addr_o, addr[mOwner]);
      checkValue("s_wdata", s_wdata_o, wdata[mOwner]);
      checkValue("s_wstrb", 32'(s_wstrb_o), 32'(strb[mOwner]));
    end
  endtask

  task automatic advance();
    @(posedge clk_i);
    #1;
    mBusy = nBusy; mOwner = nOwner; mAge = nAge; mLast = nLast;
    mErr = nErr; mErrAddr = nErrAddr; mErrMst = nErrMst;
  endtask

  task automatic runCycle(input logic [N-1:0] v, input logic rdy, input logic [31:0] rd,
                          input logic clr, input logic rs);
    applyStimulus(v, rdy, rd, clr, rs);
    checkOutput();
    advance();
  endtask

  task automatic newFields(input int k);
    addr[k]  = $urandom;
    wdata[k] = $urandom;
    strb[k]  = 4'($urandom_range(0, 15));
  endtask

  logic [N-1:0] vld, prevReady;
  int readyCnt0, readyCnt1, rdyPct;

  initial begin
    for (int k = 0; k < N; k++) begin
      addr[k] = '0; wdata[k] = '0; strb[k] = '0;
    end
    applyStimulus('0, 1'b0, '0, 1'b0, 1'b1);
    @(posedge clk_i);
    #1;
    mBusy = 0; mOwner = 0; mAge = 0; mLast = N - 1;
    mErr = 1'b0; mErrAddr = '0; mErrMst = 0;
    runCycle('0, 1'b0, '0, 1'b0, 1'b1);

    $display("[TB] reset values");
    applyStimulus('0, 1'b1, 32'h5555_AAAA, 1'b0, 1'b0);
    checkOutput();
    checkValue("reset_m_ready", 32'(m_ready_o), 32'h0);
    checkValue("reset_gnt", 32'(gnt_o), 32'h0);
    advance();

    $display("[TB] single read, slave ready after 3 cycles");
    addr[0] = 32'h1000_0000; wdata[0] = 32'h0; strb[0] = 4'h0;
    runCycle(2'b01, 1'b0, '0, 1'b0, 1'b0);
    applyStimulus(2'b01, 1'b0, '0, 1'b0, 1'b0);
    checkOutput();
    checkValue("t1_s_valid", 32'(s_valid_o), 32'h1);
    checkValue("t1_s_addr", s_addr_o, 32'h1000_0000);
    advance();
    runCycle(2'b01, 1'b0, '0, 1'b0, 1'b0);
    applyStimulus(2'b01, 1'b1, 32'h1234_5678, 1'b0, 1'b0);
    checkOutput();
    checkValue("t1_m_ready", 32'(m_ready_o), 32'h1);
    checkValue("t1_m_rdata", m_rdata_o, 32'h1234_5678);
    advance();
    runCycle(2'b00, 1'b0, '0, 1'b0, 1'b0);
    checkValue("t1_err", 32'(err_o), 32'h0);

    $display("[TB] two masters, one-cycle slave");
    addr[1] = 32'h2000_0040; wdata[1] = 32'hA5A5_0001; strb[1] = 4'hF;
    readyCnt0 = 0; readyCnt1 = 0;
    for (int c = 0; c < 8; c++) begin
      applyStimulus(2'b11, 1'b1, 32'h0BAD_0000 + 32'(c), 1'b0, 1'b0);
      checkOutput();
      if (m_ready_o[0]) readyCnt0++;
      if (m_ready_o[1]) readyCnt1++;
      advance();
    end
    checkValue("rr_ready_m0", 32'(readyCnt0), 32'd2);
    checkValue("rr_ready_m1", 32'(readyCnt1), 32'd2);
    runCycle(2'b00, 1'b0, '0, 1'b0, 1'b0);

    $display("[TB] watchdog timeout");
    for (int c = 0; c < TO; c++) runCycle(2'b10, 1'b0, '0, 1'b0, 1'b0);
    applyStimulus(2'b10, 1'b0, '0, 1'b0, 1'b0);
    checkOutput();
    checkValue("to_m_ready", 32'(m_ready_o), 32'h2);
    checkValue("to_m_rdata", m_rdata_o, 32'hDEAD_BEEF);
    checkValue("to_s_valid", 32'(s_valid_o), 32'h0);
    advance();
    applyStimulus(2'b00, 1'b0, '0, 1'b0, 1'b0);
    checkOutput();
    checkValue("to_err", 32'(err_o), 32'h1);
    checkValue("to_err_addr", err_addr_o, 32'h2000_0040);
    checkValue("to_err_mst", 32'(err_mst_o), 32'h1);
    advance();
    addr[0] = 32'h3000_0000;
    for (int c = 0; c <= TO; c++) runCycle(2'b01, 1'b0, '0, 1'b0, 1'b0);
    applyStimulus(2'b00, 1'b0, '0, 1'b0, 1'b0);
    checkOutput();
    checkValue("to2_err_addr", err_addr_o, 32'h2000_0040);
    checkValue("to2_err_mst", 32'(err_mst_o), 32'h1);
    advance();
    runCycle(2'b00, 1'b0, '0, 1'b1, 1'b0);
    applyStimulus(2'b00, 1'b0, '0, 1'b0, 1'b0);
    checkOutput();
    checkValue("clr_err", 32'(err_o), 32'h0);
    advance();

    $display("[TB] ready on the last watchdog cycle");
    for (int c = 0; c < TO; c++) runCycle(2'b01, 1'b0, '0, 1'b0, 1'b0);
    applyStimulus(2'b01, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b0);
    checkOutput();
    checkValue("edge_m_ready", 32'(m_ready_o), 32'h1);
    checkValue("edge_m_rdata", m_rdata_o, 32'hCAFE_F00D);
    advance();
    applyStimulus(2'b00, 1'b0, '0, 1'b0, 1'b0);
    checkOutput();
    checkValue("edge_err", 32'(err_o), 32'h0);
    advance();

    $display("[TB] abort and reset mid-transaction");
    runCycle(2'b10, 1'b0, '0, 1'b0, 1'b0);
    runCycle(2'b10, 1'b0, '0, 1'b0, 1'b0);
    applyStimulus(2'b00, 1'b1, 32'h7777_7777, 1'b0, 1'b0);
    checkOutput();
    checkValue("abort_s_valid", 32'(s_valid_o), 32'h0);
    checkValue("abort_m_ready", 32'(m_ready_o), 32'h0);
    advance();
    applyStimulus(2'b00, 1'b0, '0, 1'b0, 1'b0);
    checkOutput();
    checkValue("abort_gnt", 32'(gnt_o), 32'h0);
    advance();
    runCycle(2'b10, 1'b0, '0, 1'b0, 1'b0);
    runCycle(2'b10, 1'b0, '0, 1'b0, 1'b0);
    runCycle(2'b11, 1'b1, 32'h6666_6666, 1'b0, 1'b1);
    applyStimulus(2'b11, 1'b0, '0, 1'b0, 1'b0);
    checkOutput();
    checkValue("rst_gnt", 32'(gnt_o), 32'h0);
    checkValue("rst_err_addr", err_addr_o, 32'h0);
    advance();
    applyStimulus(2'b11, 1'b1, 32'h1111_2222, 1'b0, 1'b0);
    checkOutput();
    checkValue("rst_first_gnt", 32'(gnt_o), 32'h1);
    advance();
    runCycle(2'b00, 1'b0, '0, 1'b0, 1'b0);

    $display("[TB] randomized traffic");
    vld = '0;
    prevReady = '0;
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!vld[k]) begin
          if ($urandom_range(0, 9) < 4) begin
            vld[k] = 1'b1;
            newFields(k);
          end
        end else if (prevReady[k]) begin
          if ($urandom_range(0, 1) == 0) vld[k] = 1'b0;
          else newFields(k);
        end else if ($urandom_range(0, 99) < 2) begin
          vld[k] = 1'b0;
        end
      end
      rdyPct = (c < 300) ? 30 : 6;
      applyStimulus(vld, $urandom_range(0, 99) < rdyPct, $urandom,
                    $urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0);
      checkOutput();
      prevReady = eReady;
      advance();
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/nmi_rr_arbiter.md
# nmi_rr_arbiter

Round-robin arbiter sharing one NMI slave port (valid/ready/addr/wdata/wstrb/rdata) between `NUM_MST` NMI masters, e.g. the core and DMA masters in front of the bus fabric. It locks the grant for one whole transaction and adds a per-transaction watchdog. On a slave timeout it completes the stalled request with an error word and latches sticky error status for software.

## Interface
- `NUM_MST`, 2: number of masters, 2..8.
- `TIMEOUT`, 1024: maximum number of BUSY cycles without `s_ready_i`. 0 disables the watchdog.
- `ERR_RDATA`, 32'hDEAD_BEEF: read data returned on a timeout.

Ports:
- `clk_i`  in  1  single clock.
- `rst_i`  in  1  synchronous, active-high reset.
- `m_valid_i`  in  NUM_MST  per-master request.
- `m_addr_i`  in  NUM_MST*32  packed addresses; master k occupies bits [32k+31:32k].
- `m_wdata_i`  in  NUM_MST*32  packed write data.
- `m_wstrb_i`  in  NUM_MST*4  packed byte strobes; 0 means read.
- `m_rdata_o`  out  32  shared read data; valid only with the matching `m_ready_o` bit.
- `m_ready_o`  out  NUM_MST  per-master completion strobe.
- `s_valid_o`, `s_addr_o`, `s_wdata_o`, `s_wstrb_o`  out  1/32/32/4  slave request.
- `s_rdata_i`  in  32  slave read data.
- `s_ready_i`  in  1  slave completion.
- `gnt_o`  out  NUM_MST  one-hot current grant; 0 when IDLE.
- `err_clr_i`  in  1  clears the sticky error status.
- `err_o`  out  1  sticky timeout flag.
- `err_addr_o`  out  32  address of the first timed-out request.
- `err_mst_o`  out  $clog2(NUM_MST)  index of the first timed-out master.

## Operation
- FSM has two states, IDLE and BUSY.
- **IDLE.** If any `m_valid_i` bit is set, pick the first requester scanning from `last+1` modulo NUM_MST. Register its one-hot grant and index, set `last` to that index, clear the watchdog counter, and go to BUSY.
- **BUSY.**
  - `s_valid_o`=1. `s_addr_o`, `s_wdata_o` and `s_wstrb_o` are combinationally muxed from the granted master; masters hold their fields stable until ready.
  - The counter increments every BUSY cycle.
- **Completion.** `s_ready_i`=1 in BUSY drives `m_ready_o[g]`=1 and `m_rdata_o`=`s_rdata_i` in the same cycle, then returns to IDLE.
- **Timeout.** When `TIMEOUT`!=0 and the counter reaches `TIMEOUT-1` with `s_ready_i`=0:
  - `m_ready_o[g]`=1, `m_rdata_o`=`ERR_RDATA`, `s_valid_o`=0 in that cycle.
  - If `err_o` was 0: set `err_o`, latch `err_addr_o` and `err_mst_o`. Later timeouts do not overwrite them.
  - Return to IDLE.
- **Simultaneous `s_ready_i` and timeout cycle:** the slave response wins, with normal data and no error.
- **Abort.** If `m_valid_i[g]` drops in BUSY (protocol violation), return to IDLE next cycle. No `m_ready_o` is issued and `s_valid_o` drops immediately.
- `s_ready_i` in IDLE is ignored; this covers a late slave response after a timeout.
- **`err_clr_i`.** Clears `err_o`. If it coincides with a new timeout, set wins and the new address is latched.
- `m_ready_o` bits for non-granted masters are always 0. `m_rdata_o` is 0 when no ready is asserted.
- **Reset values:**
  - state IDLE; `gnt_o`=0; `last`=NUM_MST-1, so master 0 has first priority.
  - counter 0; `s_valid_o`=0; `m_ready_o`=0; `m_rdata_o`=0.
  - `err_o`=0; `err_addr_o`=0; `err_mst_o`=0.
- **Reset mid-transaction:** drops the grant immediately; no ready is issued.

## Timing
- Arbitration costs one cycle. A request seen in IDLE at cycle t appears on `s_valid_o` at t+1.
- Fastest completion is at t+1, with `s_ready_i` in the first BUSY cycle. There is always one IDLE cycle between transactions, so the maximum throughput is one transaction per 2 cycles.
- Timeout completion occurs exactly `TIMEOUT` cycles after entering BUSY.
- The counter width is $clog2(TIMEOUT+1) and the counter saturates; it never wraps.
- Fairness: a continuously requesting master waits at most NUM_MST-1 other transactions.

## Structure
- Package `nmi_arb_pkg` holds:
  - the `arb_state_e` enum (IDLE, BUSY);
  - the `NMI_AW`=32, `NMI_DW`=32 and `NMI_SW`=4 constants;
  - the default `ERR_RDATA`.
- Sub-module `rr_pick`: combinational round-robin selector. Inputs are the request vector and `last`; outputs are the one-hot winner and its index. It is reusable by other fabric arbiters.

## Test plan
- Master 0 reads 0x1000_0000 while idle; slave readies 3 cycles later returning 0x1234_5678 -> `s_valid_o` is 1 from t+1, `m_ready_o`=2'b01 with rdata 0x1234_5678 at t+3, `err_o`=0.
- Both masters request continuously with a 1-cycle slave -> grants alternate 0,1,0,1 and each master sees ready every 4 cycles.
- Slave never readies with TIMEOUT=16 -> `m_ready_o[g]` with rdata 0xDEAD_BEEF exactly 16 cycles after BUSY entry; `err_o`=1 and `err_addr_o`/`err_mst_o` are latched. A second timeout leaves them unchanged; `err_clr_i` clears `err_o`.
- `s_ready_i` in the same cycle the counter hits 15 (TIMEOUT=16) -> normal data is returned and `err_o` stays 0.
- Master 1 drops valid mid-BUSY, and separately `rst_i` pulses mid-BUSY -> no `m_ready_o`, `s_valid_o` low the next cycle, all outputs at reset values, and the next arbitration favours master 0.
